// File: rtl/fnv_lane_mix.sv
// FNV lane mixer: lanewise FNV-1 / FNV-1a multiply-xor over LANES words, or a
// sequential fold of all lanes into one W-bit digest, behind a valid/ready handshake.
module fnv_lane_mix #(
  parameter int             LANES     = 4,
  parameter int             W         = 32,
  parameter logic [W-1:0]   FNV_PRIME = 32'h01000193
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         mode,
  input  logic [LANES*W-1:0] a,
  input  logic [LANES*W-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] c,
  output logic [W-1:0]       digest,
  output logic               out_err
);

  localparam int            KW     = $clog2(LANES) + 1;
  localparam logic [KW-1:0] LAST_K = KW'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [LANES*W-1:0]   c_q, c_d;
  logic [W-1:0]         digest_q, digest_d;
  logic                 err_q, err_d;
  logic [W-1:0]         acc_q, acc_d;
  logic [KW-1:0]        k_q, k_d;
  logic [LANES*W-1:0]   fold_a_q, fold_a_d;

  logic [LANES*W-1:0]   lane_fnv1;
  logic [LANES*W-1:0]   lane_fnv1a;
  logic [W-1:0]         fold_next;
  logic                 accept;

  // Product is evaluated in a W-bit context, so bits above W-1 wrap away.
  function automatic logic [W-1:0] fnv_mul(input logic [W-1:0] x);
    logic [W-1:0] p;
    p = x * FNV_PRIME;
    return p;
  endfunction

  always_comb begin
    lane_fnv1  = '0;
    lane_fnv1a = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_fnv1[i*W +: W]  = fnv_mul(a[i*W +: W]) ^ b[i*W +: W];
      lane_fnv1a[i*W +: W] = fnv_mul(a[i*W +: W] ^ b[i*W +: W]);
    end
  end

  assign fold_next = fnv_mul(acc_q) ^ fold_a_q[int'(k_q)*W +: W];

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    digest_d = digest_q;
    err_d    = err_q;
    acc_d    = acc_q;
    k_d      = k_q;
    fold_a_d = fold_a_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          // A new request overwrites the retiring result in the same edge.
          case (mode)
            2'd0: begin
              c_d      = lane_fnv1;
              digest_d = '0;
              err_d    = 1'b0;
              state_d  = S_DONE;
            end
            2'd1: begin
              c_d      = lane_fnv1a;
              digest_d = '0;
              err_d    = 1'b0;
              state_d  = S_DONE;
            end
            2'd2: begin
              c_d      = '0;
              digest_d = '0;
              err_d    = 1'b0;
              acc_d    = a[W-1:0];
              fold_a_d = a;
              k_d      = KW'(1);
              state_d  = S_FOLD;
            end
            default: begin
              c_d      = '0;
              digest_d = '0;
              err_d    = 1'b1;
              state_d  = S_DONE;
            end
          endcase
        end else if ((state_q == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_FOLD: begin
        acc_d = fold_next;
        if (k_q == LAST_K) begin
          digest_d = fold_next;
          c_d      = '0;
          state_d  = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      c_q      <= '0;
      digest_q <= '0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      k_q      <= '0;
      fold_a_q <= '0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      digest_q <= digest_d;
      err_q    <= err_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      fold_a_q <= fold_a_d;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign c         = c_q;
  assign digest    = digest_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_fnv_lane_mix.sv
// Directed bench for fnv_lane_mix: scoreboard model of FNV lane results plus
// hand-computed literal checks of latency, handshake, stall and reset behaviour.
module tb_fnv_lane_mix;
  localparam int          LANES = 4;
  localparam int          W     = 32;
  localparam int          AW    = LANES * W;
  localparam logic [31:0] P     = 32'h01000193;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0]    mode;
  logic [AW-1:0] a, b, c;
  logic [W-1:0]  digest;

  typedef struct packed {
    logic [AW-1:0] c;
    logic [W-1:0]  d;
    logic          e;
  } res_t;

  res_t sb[$];
  int   vectors = 0;
  int   errors  = 0;
  int   retired = 0;

  fnv_lane_mix #(.LANES(LANES), .W(W), .FNV_PRIME(P)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .digest(digest), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mulp(input logic [31:0] x);
    longint unsigned t;
    t = longint'(x) * longint'(P);
    return 32'(t);
  endfunction

  // Result as defined by the mode rules, independent of any cycle timing.
  function automatic res_t model(input logic [1:0] m, input logic [AW-1:0] av, input logic [AW-1:0] bv);
    res_t r;
    logic [31:0] acc;
    r = '0;
    case (m)
      2'd0: for (int i = 0; i < LANES; i++) r.c[i*32 +: 32] = mulp(av[i*32 +: 32]) ^ bv[i*32 +: 32];
      2'd1: for (int i = 0; i < LANES; i++) r.c[i*32 +: 32] = mulp(av[i*32 +: 32] ^ bv[i*32 +: 32]);
      2'd2: begin
        acc = av[31:0];
        for (int k = 1; k < LANES; k++) acc = mulp(acc) ^ av[k*32 +: 32];
        r.d = acc;
      end
      default: r.e = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [AW-1:0] pack4(input logic [31:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chkw(input string nm, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Scoreboard bookkeeping at the active edge: retire then enqueue.
  always @(posedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && sb.size() > 0) begin
        sb.delete(0);
        retired++;
      end
      if (in_valid && in_ready) sb.push_back(model(mode, a, b));
    end
  end

  // Every cycle a result is presented it must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL sb_unexpected: got out_valid=1 expected no pending result");
      end else begin
        chkw("sb_c", c, sb[0].c);
        chk32("sb_digest", digest, sb[0].d);
        chk1("sb_err", out_err, sb[0].e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // Starts and ends #1 after a rising edge with the DUT idle and out_ready=1.
  task automatic run_one(input logic [1:0] m, input logic [AW-1:0] av, input logic [AW-1:0] bv,
                         input int exp_lat, output logic [AW-1:0] cg, output logic [31:0] dg,
                         output logic eg);
    int lat;
    logic rdy_seen;
    mode = m; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mode = 2'($urandom); a = {$urandom, $urandom, $urandom, $urandom}; b = {$urandom, $urandom, $urandom, $urandom};
    lat = 1; rdy_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    cg = c; dg = digest; eg = out_err;
    chki("latency", lat, exp_lat);
    if (exp_lat > 1) chk1("fold_in_ready_low", rdy_seen, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [AW-1:0] cg, c0;
    logic [31:0]   dg, d0;
    logic          eg, e0, seen;
    int            r0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 2'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chkw("rst_c", c, '0);
    chk32("rst_digest", digest, 32'h0);
    chk1("rst_out_err", out_err, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Mode 0, all ones
    run_one(2'd0, {4{32'h1}}, '0, 1, cg, dg, eg);
    chkw("m0_ones_c", cg, {4{32'h01000193}});
    chk32("m0_ones_digest", dg, 32'h0);
    chk1("m0_ones_err", eg, 1'b0);

    // Distinct lanes, wrap on lane 0
    run_one(2'd0, pack4(32'd3, 32'd2, 32'd1, 32'hFFFFFFFF), '0, 1, cg, dg, eg);
    chkw("m0_lanes_c", cg, pack4(32'h030004B9, 32'h02000326, 32'h01000193, 32'hFEFFFE6D));
    run_one(2'd1, pack4(0, 0, 32'd2, 0), pack4(0, 0, 32'd3, 0), 1, cg, dg, eg);
    chkw("m1_lane1_c", cg, pack4(0, 0, 32'h01000193, 0));
    run_one(2'd1, pack4(0, 32'd5, 0, 32'd1), pack4(0, 32'd5, 0, 0), 1, cg, dg, eg);
    chkw("m1_lane2_c", cg, pack4(0, 0, 0, 32'h01000193));
    run_one(2'd0, pack4(0, 0, 32'd2, 0), pack4(0, 0, 32'd3, 0), 1, cg, dg, eg);
    chkw("m0_vs_m1_c", cg, pack4(0, 0, 32'h02000325, 0));

    // Fold
    run_one(2'd2, pack4(0, 32'd1, 0, 0), '0, 4, cg, dg, eg);
    chk32("fold_a2_digest", dg, 32'h01000193);
    chkw("fold_a2_c", cg, '0);
    chk1("fold_a2_err", eg, 1'b0);
    run_one(2'd2, pack4(32'd7, 0, 0, 0), {4{32'hDEADBEEF}}, 4, cg, dg, eg);
    chk32("fold_a3_digest", dg, 32'h7);
    run_one(2'd2, pack4(32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hFFFFFFFF), '0, 4, cg, dg, eg);

    // Back-to-back mode 0 then a 3-cycle stall with a pending request
    r0 = retired;
    for (int i = 0; i < 8; i++) begin
      mode = 2'd0; b = '0; in_valid = 1'b1;
      a = pack4(32'(i + 4), 32'(i + 3), 32'(i + 2), 32'(i + 1));
      @(negedge clk);
      chk1("b2b_in_ready", in_ready, 1'b1);
      if (i > 0) chk1("b2b_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    a = {4{32'h00000010}}; b = {4{32'h5}};
    out_ready = 1'b0;
    @(negedge clk);
    c0 = c; d0 = digest; e0 = out_err;
    chkw("b2b_last_c", c, pack4(32'h0B001151, 32'h0A000FBE, 32'h09000E2B, 32'h08000C98));
    chk1("stall_in_ready", in_ready, 1'b0);
    for (int s = 0; s < 2; s++) begin
      @(posedge clk); #1;
      a = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk1("stall_out_valid", out_valid, 1'b1);
      chk1("stall_in_ready", in_ready, 1'b0);
      chkw("stall_c_frozen", c, c0);
      chk32("stall_digest_frozen", digest, d0);
      chk1("stall_err_frozen", out_err, e0);
    end
    @(posedge clk); #1;
    a = {4{32'h00000010}};
    out_ready = 1'b1;
    @(negedge clk);
    chk1("unstall_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("after_stall_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    chki("b2b_retired", retired - r0, 9);

    // Reset in cycle 2 of a fold
    mode = 2'd2; a = pack4(32'd5, 32'd6, 32'd7, 32'd8); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; mode = 2'd0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_ready", in_ready, 1'b1);
    chkw("post_rst_c", c, '0);
    chk32("post_rst_digest", digest, 32'h0);
    seen = out_valid;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk1("fold_aborted_no_output", seen, 1'b0);
    @(posedge clk); #1;
    run_one(2'd0, {4{32'h1}}, pack4(32'h1, 32'h2, 32'h3, 32'h4), 1, cg, dg, eg);
    chkw("post_rst_m0_c", cg, pack4(32'h01000192, 32'h01000191, 32'h01000190, 32'h01000197));

    // Reset while a result is stalled in DONE
    out_ready = 1'b0; mode = 2'd0; a = {4{32'h1}}; b = '0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("stalled_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk1("rst_done_out_valid", out_valid, 1'b0);
    chkw("rst_done_c", c, '0);
    @(posedge clk); #1;

    // Reserved mode, then a normal request clears the error flag
    run_one(2'd3, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1, cg, dg, eg);
    chk1("m3_err", eg, 1'b1);
    chkw("m3_c", cg, '0);
    chk32("m3_digest", dg, 32'h0);
    run_one(2'd0, {4{32'h2}}, '0, 1, cg, dg, eg);
    chk1("m0_after_m3_err", eg, 1'b0);
    chkw("m0_after_m3_c", cg, {4{32'h02000326}});

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/fnv_lane_mix.md
FNV_LANE_MIX -- requirements
Module: fnv_lane_mix

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent W-bit lanes (legal range 2..16).
REQ-002 SHALL have parameter W, default 32, lane word width in bits.
REQ-003 SHALL have parameter FNV_PRIME, default 32'h01000193, W-bit multiplier constant.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  request present.
REQ-007 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-008 SHALL have port mode  input  2  0=FNV-1 lanewise, 1=FNV-1a lanewise, 2=fold, 3=reserved.
REQ-009 SHALL have port a  input  LANES*W  operand lanes; lane i = a[i*W +: W].
REQ-010 SHALL have port b  input  LANES*W  operand lanes; ignored in fold mode.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-013 SHALL have port c  output  LANES*W  lanewise result.
REQ-014 SHALL have port digest  output  W  fold result.
REQ-015 SHALL have port out_err  output  1  result came from a reserved mode.

Function
REQ-016 SHALL complete a request when in_valid && in_ready at a rising edge (accept cycle 0) and SHALL capture mode, a and b at that edge; later input changes SHALL have no effect on that request.
REQ-017 SHALL implement a three-state FSM: IDLE, FOLD, DONE.
REQ-018 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), combinationally.
REQ-019 SHALL drive out_valid = (state==DONE).
REQ-020 SHALL, in mode 0, compute every lane independently: c_i = (a_i*FNV_PRIME mod 2^W) ^ b_i.
REQ-021 SHALL, in mode 1, compute every lane independently: c_i = ((a_i ^ b_i)*FNV_PRIME) mod 2^W.
REQ-022 SHALL, in modes 0/1, move to DONE at the accept edge, with out_valid high in cycle 1 and digest=0.
REQ-023 SHALL, in mode 2, load acc=a_0 at accept and enter FOLD, then perform step k (k=1..LANES-1) acc=(acc*FNV_PRIME mod 2^W) ^ a_k at the edge ending cycle k.
REQ-024 SHALL, in mode 2, enter DONE after step LANES-1, with out_valid high in cycle LANES, digest=acc and c=0.
REQ-025 SHALL, in mode 3, enter DONE at the accept edge, with out_valid high in cycle 1, out_err=1, c=0 and digest=0; out_err SHALL be 0 for modes 0..2.
REQ-026 SHALL hold c, digest and out_err stable in DONE while out_ready=0.
REQ-027 SHALL, in DONE with out_ready=1 and in_valid=0, return to IDLE.
REQ-028 SHALL, in DONE with out_ready=1 and in_valid=1, retire the current result and accept the new request on the same edge, giving sustained one-per-cycle throughput for modes 0/1/3.
REQ-029 SHALL hold in_ready=0 throughout FOLD, and in_valid during FOLD SHALL be ignored.
REQ-030 SHALL discard all multiplier bits above bit W-1; overflow SHALL wrap silently.

Reset
REQ-031 SHALL, on a cycle with rst=1, set state=IDLE, out_valid=0, c=0, digest=0, out_err=0 and acc=0 at the next edge, regardless of current state, including mid-FOLD or stalled DONE.
REQ-032 SHALL discard an in-flight request on reset and SHALL NOT produce its result.
REQ-033 SHALL ignore in_valid while rst=1, and SHALL assert in_ready in the first cycle after rst deasserts.

Verification
REQ-034 SHALL pass: LANES=4, mode 0, all a_i=1, b_i=0 -> out_valid in cycle 1, every lane of c = 0x01000193, digest=0.
REQ-035 SHALL pass: mode 0, a_0=0xFFFFFFFF, b_0=0; mode 1, a_1=2, b_1=3; mode 1, a_2=b_2=5 -> c_0=0xFEFFFE6D, c_1=0x01000193, c_2=0; lanes are distinct, with no lane-0 broadcast.
REQ-036 SHALL pass: mode 2, a={a0=0,a1=0,a2=1,a3=0} -> in_ready=0 for cycles 1..3, out_valid in cycle 4, digest=0x01000193, c=0; a3=7 with others 0 -> digest=7.
REQ-037 SHALL pass: 8 back-to-back mode-0 requests with out_ready=1, then out_ready low for 3 cycles -> 8 results in order, one per cycle; outputs frozen during the stall; in_ready low during the stall.
REQ-038 SHALL pass: mode 2 accepted, rst=1 in cycle 2 -> out_valid never rises for that request; in_ready=1 in the cycle after rst falls; the next mode-0 request completes normally.
REQ-039 SHALL pass: mode 3 with random a/b -> out_valid in cycle 1, out_err=1, c=0, digest=0; the following mode-0 result has out_err=0.
